// File: rtl/gate_tester_pkg.sv
// Shared types and constants for the quad 2-input gate tester: FSM states,
// vector count, standard truth tables and the expected-output helper.
package gate_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int         NUM_VECTORS = 4;
  localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

  // Truth tables indexed by {A,B}: bit 2*A+B is the gate output.
  localparam logic [3:0] FUNC_AND  = 4'b1000;
  localparam logic [3:0] FUNC_NAND = 4'b0111;
  localparam logic [3:0] FUNC_OR   = 4'b1110;
  localparam logic [3:0] FUNC_NOR  = 4'b0001;
  localparam logic [3:0] FUNC_XOR  = 4'b0110;

  // Vector v applies A=v[0], B=v[1] to all four gates (order 00,10,01,11).
  function automatic logic [3:0] expected_y(input logic [3:0] func, input logic [1:0] v);
    return {4{func[{v[0], v[1]}]}};
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle down-counter: load arms it with CYCLES, count decrements it, and
// expired flags the final settle cycle so the FSM leaves on that edge.
module settle_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired
);

  logic [7:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 8'(CYCLES);
    end else if (count && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expired = (cnt <= 8'd1);

endmodule

// File: rtl/gate_tester.sv
// Sequences the four {A,B} vectors into a quad 2-input gate, waits for the
// outputs to settle, checks Y against the truth table and reports the result.
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] GATE_FUNC     = FUNC_AND,
  parameter bit         STOP_ON_FAIL  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic [3:0] Y,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [3:0] FailMask,
  output logic [1:0] FailVec
);

  state_t     state;
  logic [1:0] v;
  logic [1:0] v_next;
  logic [3:0] expected;
  logic [3:0] mism;
  logic [3:0] mask_next;
  logic       timer_load;
  logic       timer_count;
  logic       timer_expired;

  assign timer_load  = (state == ST_DRIVE);
  assign timer_count = (state == ST_SETTLE);

  settle_timer #(
    .CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (CLK),
    .rst    (RST),
    .load   (timer_load),
    .count  (timer_count),
    .expired(timer_expired)
  );

  assign expected  = expected_y(GATE_FUNC, v);
  assign mask_next = FailMask | mism;
  assign v_next    = v + 2'd1;

  // NOTE: every always_comb output gets a default first so no path can infer
  // a latch. The if/else form also sends an X/Z compare down the mismatch arm.
  always_comb begin
    mism = '0;
    for (int i = 0; i < 4; i++) begin
      if (Y[i] == expected[i]) mism[i] = 1'b0;
      else                     mism[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      v        <= '0;
      A        <= '0;
      B        <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Pass     <= 1'b0;
      FailMask <= '0;
      FailVec  <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            FailMask <= '0;
            FailVec  <= '0;
            Pass     <= 1'b0;
            v        <= '0;
            A        <= '0;
            B        <= '0;
            Busy     <= 1'b1;
            state    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          state <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_expired) state <= ST_CHECK;
        end
        ST_CHECK: begin
          FailMask <= mask_next;
          if (mism != 4'd0 && FailMask == 4'd0) FailVec <= v;
          if (v == LAST_VEC || (STOP_ON_FAIL && mism != 4'd0)) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            Pass  <= (mask_next == 4'd0);
            state <= ST_DONE;
          end else begin
            v     <= v_next;
            A     <= {4{v_next[0]}};
            B     <= {4{v_next[1]}};
            state <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          // Start is not looked at here; a held Start restarts from IDLE.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tester.sv
// Scoreboard bench for gate_tester: three instances (AND/stop, AND/no-stop,
// NAND/no-settle) with behavioural gate models and injectable faults.
module tb_gate_tester;
  import gate_tester_pkg::*;

  typedef struct {
    string      name;
    logic       pass;
    logic [3:0] mask;
    logic [1:0] vec;
    bit         chk_vec;
    int         latency;
    int         done_cyc;
    logic [3:0] a_last;
    logic [3:0] b_last;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [3:0] a_a, b_a, y_a, mask_a;
  logic [3:0] a_b, b_b, y_b, mask_b;
  logic [3:0] a_c, b_c, y_c, mask_c;
  logic       busy_a, done_a, pass_a;
  logic       busy_b, done_b, pass_b;
  logic       busy_c, done_c, pass_c;
  logic [1:0] vec_a, vec_b, vec_c;
  int fault_a = 0;
  int fault_b = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  gate_tester #(.SETTLE_CYCLES(4), .GATE_FUNC(FUNC_AND), .STOP_ON_FAIL(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .Start(start_a), .A(a_a), .B(b_a), .Y(y_a),
    .Busy(busy_a), .Done(done_a), .Pass(pass_a), .FailMask(mask_a), .FailVec(vec_a));

  gate_tester #(.SETTLE_CYCLES(4), .GATE_FUNC(FUNC_AND), .STOP_ON_FAIL(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .Start(start_b), .A(a_b), .B(b_b), .Y(y_b),
    .Busy(busy_b), .Done(done_b), .Pass(pass_b), .FailMask(mask_b), .FailVec(vec_b));

  gate_tester #(.SETTLE_CYCLES(0), .GATE_FUNC(FUNC_NAND), .STOP_ON_FAIL(1'b1)) dut_c (
    .CLK(CLK), .RST(RST), .Start(start_c), .A(a_c), .B(b_c), .Y(y_c),
    .Busy(busy_c), .Done(done_c), .Pass(pass_c), .FailMask(mask_c), .FailVec(vec_c));

  // Gate models: 7408 AND with optional Y3 stuck-at-0; AND with Y1 stuck-at-1
  // or Y2 floating; 7400 NAND.
  always_comb begin
    y_a = a_a & b_a;
    if (fault_a == 1) y_a[2] = 1'b0;
  end

  always_comb begin
    y_b = a_b & b_b;
    if (fault_b == 1) y_b[0] = 1'b1;
    if (fault_b == 2) y_b[1] = 1'bx;
  end

  assign y_c = ~(a_c & b_c);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic score(input exp_t e, input logic pass, input logic [3:0] mask,
                       input logic [1:0] vec, input logic busy,
                       input logic [3:0] a, input logic [3:0] b);
    check({e.name, " Pass"}, 32'(pass), 32'(e.pass));
    check({e.name, " FailMask"}, 32'(mask), 32'(e.mask));
    if (e.chk_vec) check({e.name, " FailVec"}, 32'(vec), 32'(e.vec));
    check({e.name, " Done cycle"}, 32'(cyc), 32'(e.done_cyc));
    check({e.name, " Busy at Done"}, 32'(busy), 32'd0);
    check({e.name, " A held"}, 32'(a), 32'(e.a_last));
    check({e.name, " B held"}, 32'(b), 32'(e.b_last));
  endtask

  // Monitors: each Done pulse pops the oldest expectation for that instance.
  always @(negedge CLK) begin
    if (done_a) begin
      if (q_a.size() == 0) check("unexpected Done A", 32'(done_a), 32'd0);
      else score(q_a.pop_front(), pass_a, mask_a, vec_a, busy_a, a_a, b_a);
    end
    if (done_b) begin
      if (q_b.size() == 0) check("unexpected Done B", 32'(done_b), 32'd0);
      else score(q_b.pop_front(), pass_b, mask_b, vec_b, busy_b, a_b, b_b);
    end
    if (done_c) begin
      if (q_c.size() == 0) check("unexpected Done C", 32'(done_c), 32'd0);
      else score(q_c.pop_front(), pass_c, mask_c, vec_c, busy_c, a_c, b_c);
    end
  end

  function automatic exp_t mk(input string name, input logic pass, input logic [3:0] mask,
                              input logic [1:0] vec, input bit chk_vec, input int latency,
                              input logic [3:0] a_last, input logic [3:0] b_last);
    exp_t e;
    e.name = name; e.pass = pass; e.mask = mask; e.vec = vec; e.chk_vec = chk_vec;
    e.latency = latency; e.done_cyc = 0; e.a_last = a_last; e.b_last = b_last;
    return e;
  endfunction

  // Issues a one-cycle Start to instance `which`; push=0 starts with no expectation.
  task automatic kick(input int which, input exp_t e, input bit push);
    @(negedge CLK);
    e.done_cyc = cyc + e.latency;
    if (push) begin
      case (which)
        0: q_a.push_back(e);
        1: q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
    case (which)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge CLK);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    case (which)
      0: check({e.name, " Busy after Start"}, 32'(busy_a), 32'd1);
      1: check({e.name, " Busy after Start"}, 32'(busy_b), 32'd1);
      default: check({e.name, " Busy after Start"}, 32'(busy_c), 32'd1);
    endcase
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0) break;
      @(negedge CLK);
    end
    check({name, " drained"}, 32'(q_a.size() + q_b.size() + q_c.size()), 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge CLK);
    check("reset A/B inst a", {24'd0, a_a, b_a}, 32'd0);
    check("reset flags inst a", {27'd0, busy_a, done_a, pass_a, vec_a}, 32'd0);
    check("reset FailMask inst a", 32'(mask_a), 32'd0);
    check("reset flags inst b", {19'd0, a_b, b_b, busy_b, done_b, pass_b, mask_b[1:0]}, 32'd0);
    check("reset flags inst c", {20'd0, a_c, b_c, busy_c, done_c, pass_c, vec_c[0]}, 32'd0);
    RST = 1'b0;

    // 7408 connected, clean run: Done in cycle 25.
    kick(0, mk("and_clean", 1'b1, 4'b0000, 2'd0, 1'b1, 25, 4'hF, 4'hF), 1'b1);
    drain("and_clean", 60);

    // Y3 stuck-at-0 with abort: only vector 3 can expose it.
    fault_a = 1;
    kick(0, mk("y3_sa0_abort", 1'b0, 4'b0100, 2'd3, 1'b1, 25, 4'hF, 4'hF), 1'b1);
    drain("y3_sa0_abort", 60);
    fault_a = 0;

    // Y1 stuck-at-1, no abort: fails first at vector 0, run still completes.
    fault_b = 1;
    kick(1, mk("y1_sa1_full", 1'b0, 4'b0001, 2'd0, 1'b1, 25, 4'hF, 4'hF), 1'b1);
    drain("y1_sa1_full", 60);

    // Reset during SETTLE of vector 1 (cycle 9 after Start): abandon, no Done.
    e = mk("reset_mid", 1'b0, 4'b0000, 2'd0, 1'b0, 25, 4'h0, 4'h0);
    kick(1, e, 1'b0);
    repeat (8) @(negedge CLK);
    check("reset_mid pre-reset A", 32'(a_b), 32'hF);
    check("reset_mid pre-reset FailMask", 32'(mask_b), 32'h1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("reset_mid A/B", {24'd0, a_b, b_b}, 32'd0);
    check("reset_mid flags", {27'd0, busy_b, done_b, pass_b, vec_b}, 32'd0);
    check("reset_mid FailMask", 32'(mask_b), 32'd0);
    repeat (35) @(negedge CLK);
    fault_b = 0;

    // No settle, NAND truth table against a NAND model: Done in cycle 9.
    kick(2, mk("nand_nosettle", 1'b1, 4'b0000, 2'd0, 1'b1, 9, 4'hF, 4'hF), 1'b1);
    drain("nand_nosettle", 30);

    // Start re-pulsed while Busy is ignored; exactly one Done at cycle 25.
    kick(0, mk("repulse", 1'b1, 4'b0000, 2'd0, 1'b1, 25, 4'hF, 4'hF), 1'b1);
    repeat (4) @(negedge CLK);
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    drain("repulse", 60);
    repeat (30) @(negedge CLK);

    // Y2 undriven: its FailMask bit must be set whichever vector exposes it.
    fault_b = 2;
    kick(1, mk("y2_x", 1'b0, 4'b0010, 2'd0, 1'b0, 25, 4'hF, 4'hF), 1'b1);
    drain("y2_x", 60);
    fault_b = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
